// File: rtl/serial_exec_ctrl_pkg.sv
// Shared opcode, ALU function and FSM encodings for the bit-serial CPU sequencer.
package serial_exec_ctrl_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_LDI = 4'h8;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_XOR  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CLS_NOP     = 2'd0,
    CLS_ALU     = 2'd1,
    CLS_LDI     = 2'd2,
    CLS_ILLEGAL = 2'd3
  } op_class_e;

  function automatic op_class_e classify(input logic [3:0] op);
    op_class_e cls;
    case (op)
      OP_NOP:                                 cls = CLS_NOP;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR:  cls = CLS_ALU;
      OP_LDI:                                 cls = CLS_LDI;
      default:                                cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/serial_exec_ctrl_bit_counter.sv
// Loadable up-counter for the serial bit index; wraps to 0 when advanced at WIDTH-1.
module serial_exec_ctrl_bit_counter
  import serial_exec_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [BW-1:0] cnt_o,
  output logic          tc_o
);

  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

  logic [BW-1:0] cnt_q, cnt_d;

  // Explicit compare keeps non-power-of-2 widths correct.
  assign tc_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = tc_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/serial_exec_ctrl.sv
// Sequencer for the bit-serial datapath: le, ae, bit index, carry seed, write-back.
// Optional single-step EXEC gated by `step_i` when SEC_STEP_EN is defined.
module serial_exec_ctrl
  import serial_exec_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic [3:0]    opcode_i,
`ifdef SEC_STEP_EN
  input  logic          step_i,
`endif
  output logic          busy_o,
  output logic          le_o,
  output logic          ae_o,
  output logic [BW-1:0] bit_idx_o,
  output logic          carry_init_o,
  output logic [2:0]    alu_op_o,
  output logic          wb_o,
  output logic          done_o,
  output logic          illegal_o
);

  // state | meaning
  // IDLE  | waiting for start; NOP/illegal answered from here
  // LOAD  | le pulse, carry seed and ALU function presented
  // EXEC  | one ae cycle per operand bit, LSB first
  // WB    | wb + done pulse, back to IDLE

  state_e        state_q, state_d;
  logic [3:0]    op_q, op_d;
  logic          start_q;
  logic          busy_q, busy_d;
  logic          le_q, le_d;
  logic          ae_q, ae_d;
  logic          carry_q, carry_d;
  logic [2:0]    alu_op_q, alu_op_d;
  logic          wb_q, wb_d;
  logic          done_q, done_d;
  logic          illegal_q, illegal_d;
  logic          cnt_clr, cnt_inc, cnt_tc;
  logic [BW-1:0] cnt;
  logic          accept;
  logic          adv;

`ifdef SEC_STEP_EN
  assign adv = step_i;
`else
  assign adv = 1'b1;
`endif

  // Rising edge only, and never while busy or in a done cycle.
  assign accept = start_i & ~start_q & (state_q == ST_IDLE) & ~done_q;

  serial_exec_ctrl_bit_counter #(
    .WIDTH (WIDTH),
    .BW    (BW)
  ) u_bit_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (cnt_clr),
    .inc_i (cnt_inc),
    .cnt_o (cnt),
    .tc_o  (cnt_tc)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    le_d      = 1'b0;
    ae_d      = 1'b0;
    carry_d   = 1'b0;
    alu_op_d  = alu_op_q;
    wb_d      = 1'b0;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d = opcode_i;
          case (classify(opcode_i))
            CLS_NOP: done_d = 1'b1;
            CLS_ALU: begin
              state_d  = ST_LOAD;
              le_d     = 1'b1;
              carry_d  = (opcode_i == OP_SUB);
              alu_op_d = opcode_i[2:0];
              cnt_clr  = 1'b1;
            end
            CLS_LDI: begin
              state_d  = ST_LOAD;
              le_d     = 1'b1;
              alu_op_d = ALU_PASS;
              cnt_clr  = 1'b1;
            end
            default: begin
              illegal_d = 1'b1;
              done_d    = 1'b1;
            end
          endcase
        end
      end
      ST_LOAD: begin
        if (op_q == OP_LDI) begin
          state_d = ST_WB;
          wb_d    = 1'b1;
          done_d  = 1'b1;
        end else begin
          state_d = ST_EXEC;
          ae_d    = 1'b1;
        end
      end
      ST_EXEC: begin
        if (adv) begin
          cnt_inc = 1'b1;
          if (cnt_tc) begin
            state_d = ST_WB;
            wb_d    = 1'b1;
            done_d  = 1'b1;
          end else begin
            ae_d = 1'b1;
          end
        end else begin
          ae_d = 1'b1;
        end
      end
      ST_WB: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_NOP;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      le_q      <= 1'b0;
      ae_q      <= 1'b0;
      carry_q   <= 1'b0;
      alu_op_q  <= ALU_PASS;
      wb_q      <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      start_q   <= start_i;
      busy_q    <= busy_d;
      le_q      <= le_d;
      ae_q      <= ae_d;
      carry_q   <= carry_d;
      alu_op_q  <= alu_op_d;
      wb_q      <= wb_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  assign busy_o       = busy_q;
  assign le_o         = le_q;
  // In step mode ae must coincide with the step pulse itself, so it is gated here.
  assign ae_o         = ae_q & adv;
  assign bit_idx_o    = cnt;
  assign carry_init_o = carry_q;
  assign alu_op_o     = alu_op_q;
  assign wb_o         = wb_q;
  assign done_o       = done_q;
  assign illegal_o    = illegal_q;

endmodule

// File: tb/tb_serial_exec_ctrl.sv
// Randomised self-checking bench for serial_exec_ctrl against a cycle-timeline model.
module tb_serial_exec_ctrl;

  localparam int W  = 8;
  localparam int BW = 3;
  localparam int VW = 10 + BW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start_i = 1'b0;
  logic [3:0]    opcode_i = 4'h0;
  logic          busy_o, le_o, ae_o, carry_init_o, wb_o, done_o, illegal_o;
  logic [BW-1:0] bit_idx_o;
  logic [2:0]    alu_op_o;
`ifdef SEC_STEP_EN
  logic          step_i = 1'b1;
`endif

  int vectors = 0;
  int errors  = 0;
  logic [2:0] m_alu_op = 3'b000;

  serial_exec_ctrl #(.WIDTH(W), .BW(BW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .opcode_i     (opcode_i),
`ifdef SEC_STEP_EN
    .step_i       (step_i),
`endif
    .busy_o       (busy_o),
    .le_o         (le_o),
    .ae_o         (ae_o),
    .bit_idx_o    (bit_idx_o),
    .carry_init_o (carry_init_o),
    .alu_op_o     (alu_op_o),
    .wb_o         (wb_o),
    .done_o       (done_o),
    .illegal_o    (illegal_o)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] observed();
    return {busy_o, le_o, ae_o, bit_idx_o, carry_init_o, alu_op_o, wb_o, done_o, illegal_o};
  endfunction

  function automatic bit is_alu(input logic [3:0] op);
    return (op >= 4'h1) && (op <= 4'h5);
  endfunction

  // Cycles from acceptance to the done pulse.
  function automatic int op_last(input logic [3:0] op);
    if (is_alu(op)) return W + 2;
    if (op == 4'h8) return 2;
    return 1;
  endfunction

  // Expected outputs k cycles after the accepting edge (k > last means idle).
  function automatic logic [VW-1:0] expect_at(input logic [3:0] op, input int k, input logic [2:0] aop);
    bit loads, ill, busy, le, ae, carry, wb, done, illg;
    int last;
    logic [BW-1:0] idx;
    last  = op_last(op);
    loads = is_alu(op) || (op == 4'h8);
    ill   = !loads && (op != 4'h0);
    busy  = loads && (k >= 1) && (k <= last);
    le    = loads && (k == 1);
    ae    = is_alu(op) && (k >= 2) && (k <= W + 1);
    idx   = ae ? BW'(k - 2) : '0;
    carry = (op == 4'h2) && (k == 1);
    wb    = loads && (k == last);
    done  = (k == last);
    illg  = ill && (k == 1);
    return {busy, le, ae, idx, carry, aop, wb, done, illg};
  endfunction

  // Caller must be at a negedge with start_i low in the previous cycle.
  task automatic run_op(input logic [3:0] op, input int poke, input string name);
    logic [VW-1:0] got, exp;
    int last;
    last = op_last(op);
    if (is_alu(op)) m_alu_op = op[2:0];
    else if (op == 4'h8) m_alu_op = 3'b000;
    start_i  = 1'b1;
    opcode_i = op;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      got = observed();
      exp = expect_at(op, k, m_alu_op);
      vectors++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s op=%h k=%0d got=%b exp=%b", name, op, k, got, exp);
      end
      start_i  = (k == poke);
      opcode_i = 4'($urandom);
    end
  endtask

  task automatic idle_check(input int n, input string name);
    logic [VW-1:0] got, exp;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      got = observed();
      exp = {3'b000, {BW{1'b0}}, 1'b0, m_alu_op, 3'b000};
      vectors++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s idle=%0d got=%b exp=%b", name, i, got, exp);
      end
      start_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (observed() !== '0) begin
      errors++;
      $display("FAIL reset_async got=%b exp=%b", observed(), {VW{1'b0}});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_alu_op = 3'b000;
    idle_check(2, "reset_release");
  endtask

  task automatic test_directed();
    run_op(4'h1, 0, "add");        idle_check(1, "add_after");
    run_op(4'h2, 0, "sub");        idle_check(1, "sub_after");
    run_op(4'h8, 0, "ldi");        idle_check(1, "ldi_after");
    run_op(4'h0, 0, "nop");        idle_check(1, "nop_after");
    run_op(4'hB, 0, "illegal_b");  idle_check(1, "illegal_after");
    run_op(4'h5, 0, "xor");        idle_check(1, "xor_after");
  endtask

  task automatic test_ignored_start();
    run_op(4'h1, 4, "add_poke_t4");     idle_check(1, "poke_t4_after");
    run_op(4'h8, 2, "ldi_poke_done");   idle_check(2, "poke_done_after");
    run_op(4'h0, 1, "nop_poke_done");   idle_check(2, "nop_poke_after");
  endtask

  task automatic test_back_to_back();
    run_op(4'h3, 0, "b2b_and");
    idle_check(1, "b2b_gap");
    run_op(4'h4, 0, "b2b_or");
    idle_check(1, "b2b_gap2");
    run_op(4'h8, 0, "b2b_ldi");
    idle_check(1, "b2b_end");
  endtask

  task automatic test_reset_mid();
    logic [VW-1:0] got, exp;
    m_alu_op = 3'b001;
    start_i  = 1'b1;
    opcode_i = 4'h1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      got = observed();
      exp = expect_at(4'h1, k, m_alu_op);
      vectors++;
      if (got !== exp) begin
        errors++;
        $display("FAIL mid_add k=%0d got=%b exp=%b", k, got, exp);
      end
      start_i = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (observed() !== '0) begin
      errors++;
      $display("FAIL mid_reset_async got=%b exp=%b", observed(), {VW{1'b0}});
    end
    @(negedge clk);
    vectors++;
    if (observed() !== '0) begin
      errors++;
      $display("FAIL mid_reset_held got=%b exp=%b", observed(), {VW{1'b0}});
    end
    rst_n = 1'b1;
    m_alu_op = 3'b000;
    idle_check(3, "post_reset_idle");
    run_op(4'h1, 0, "post_reset_add");
    idle_check(1, "post_reset_after");
  endtask

  task automatic test_random();
    logic [3:0] op;
    int sel, poke, gap, last;
    logic [3:0] bad [10];
    bad = '{4'h6, 4'h7, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h7};
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 5)       op = 4'($urandom_range(1, 5));
      else if (sel == 5) op = 4'h8;
      else if (sel == 6) op = 4'h0;
      else if (sel == 7) op = bad[$urandom_range(0, 9)];
      else               op = 4'($urandom);
      last = op_last(op);
      poke = ($urandom_range(0, 2) == 0) ? $urandom_range(1, last) : 0;
      gap  = (poke == last) ? 2 : $urandom_range(1, 3);
      run_op(op, poke, "random");
      idle_check(gap, "random_gap");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
